// File: rtl/disp_scan_ctrl_if.sv
// Frame-update port of the 7-segment scan sequencer: the upstream offers a display word
// with valid/ready, and the sequencer accepts it only at a frame boundary.
interface disp_scan_ctrl_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_hexs;
    logic [3:0]  upd_point;
    logic [3:0]  upd_les;

    modport master (
        output upd_valid,
        output upd_hexs,
        output upd_point,
        output upd_les,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_hexs,
        input  upd_point,
        input  upd_les,
        output upd_ready
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Scan sequencer for a 4-digit 7-segment multiplexer: digit-select divider, frame-aligned
// loading of the displayed word, and a frame-rate blink phase gating the blink enables.
module disp_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    disp_scan_ctrl_if.slave      upd,
    output logic [15:0]          Hexs,
    output logic [3:0]           Point,
    output logic [3:0]           Les,
    output logic [1:0]           Scan,
    output logic                 frame_start,
    output logic                 blink_phase
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_r;
    logic [1:0]       scan_r;
    logic [15:0]      hexs_r;
    logic [3:0]       point_r;
    logic [3:0]       les_r;
    logic [FC_W-1:0]  frame_cnt_r;
    logic             blink_r;
    logic             frame_start_r;

    logic             tick_s;
    logic             frame_end_s;
    logic             accept_s;
    logic [DIV_W-1:0] div_nxt_s;
    logic [1:0]       scan_nxt_s;
    logic [15:0]      hexs_nxt_s;
    logic [3:0]       point_nxt_s;
    logic [3:0]       les_nxt_s;
    logic [FC_W-1:0]  frame_cnt_nxt_s;
    logic             blink_nxt_s;

    // Next-state logic: divider/scan, frame-aligned word load and blink counter act independently.
    always_comb begin
        tick_s          = (div_r == DIV_LAST);
        frame_end_s     = tick_s && (scan_r == 2'd3);
        accept_s        = upd.upd_valid && frame_end_s && rstn;
        div_nxt_s       = div_r;
        scan_nxt_s      = scan_r;
        hexs_nxt_s      = hexs_r;
        point_nxt_s     = point_r;
        les_nxt_s       = les_r;
        frame_cnt_nxt_s = frame_cnt_r;
        blink_nxt_s     = blink_r;

        if (tick_s) begin
            div_nxt_s  = {DIV_W{1'b0}};
            scan_nxt_s = scan_r + 2'd1;
        end else begin
            div_nxt_s  = div_r + DIV_W'(1);
        end

        // Loading at frame_end makes new content appear exactly when Scan wraps to digit 0.
        if (accept_s) begin
            hexs_nxt_s  = upd.upd_hexs;
            point_nxt_s = upd.upd_point;
            les_nxt_s   = upd.upd_les;
        end else begin
            hexs_nxt_s  = hexs_r;
        end

        if (frame_end_s) begin
            if (frame_cnt_r == FC_LAST) begin
                frame_cnt_nxt_s = {FC_W{1'b0}};
                blink_nxt_s     = ~blink_r;
            end else begin
                frame_cnt_nxt_s = frame_cnt_r + FC_W'(1);
            end
        end else begin
            frame_cnt_nxt_s = frame_cnt_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_r         <= {DIV_W{1'b0}};
            scan_r        <= 2'd0;
            hexs_r        <= 16'h0000;
            point_r       <= 4'hF;
            les_r         <= 4'h0;
            frame_cnt_r   <= {FC_W{1'b0}};
            blink_r       <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            div_r         <= div_nxt_s;
            scan_r        <= scan_nxt_s;
            hexs_r        <= hexs_nxt_s;
            point_r       <= point_nxt_s;
            les_r         <= les_nxt_s;
            frame_cnt_r   <= frame_cnt_nxt_s;
            blink_r       <= blink_nxt_s;
            frame_start_r <= frame_end_s;
        end
    end

    assign upd.upd_ready = frame_end_s && rstn;
    assign Hexs          = hexs_r;
    assign Point         = point_r;
    assign Les           = les_r & {4{blink_r}};
    assign Scan          = scan_r;
    assign frame_start   = frame_start_r;
    assign blink_phase   = blink_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: expected outputs come from elapsed-time arithmetic
// (cycles since the last reset edge) plus a record of every accepted display word.
module tb_disp_scan_ctrl;

    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
    logic [1:0]  scan;
    logic        fs;
    logic        bp;

    disp_scan_ctrl_if u_if ();

    disp_scan_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .upd         (u_if.slave),
        .Hexs        (hexs),
        .Point       (point),
        .Les         (les),
        .Scan        (scan),
        .frame_start (fs),
        .blink_phase (bp)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          t;
    logic [15:0] m_hexs;
    logic [3:0]  m_point;
    logic [3:0]  m_les;
    logic        up_v;
    logic [15:0] up_h;
    logic [3:0]  up_p;
    logic [3:0]  up_l;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0d observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t       = 0;
        m_hexs  = 16'h0000;
        m_point = 4'hF;
        m_les   = 4'h0;
    endtask

    // One clock cycle: drive inputs, check every output against the time-based model, advance.
    task automatic tick(input logic r, output logic acc);
        logic exp_rdy;
        int   ph;
        rstn           = r;
        u_if.upd_valid = up_v;
        u_if.upd_hexs  = up_h;
        u_if.upd_point = up_p;
        u_if.upd_les   = up_l;
        #1;
        exp_rdy = r && ((t % FRAME) == FRAME - 1);
        ph      = (t / (FRAME * BF)) % 2;
        check_eq("upd_ready",   u_if.upd_ready, exp_rdy);
        check_eq("scan",        scan, (t / SD) % 4);
        check_eq("frame_start", fs, (t > 0) && ((t % FRAME) == 0));
        check_eq("blink_phase", bp, ph);
        check_eq("hexs",        hexs, m_hexs);
        check_eq("point",       point, m_point);
        check_eq("les",         les, m_les & {4{ph[0]}});
        acc = up_v && exp_rdy;
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            if (acc) begin
                m_hexs  = up_h;
                m_point = up_p;
                m_les   = up_l;
            end
            t++;
        end
        @(negedge clk);
    endtask

    // Offer a word until it is accepted (bounded); returns the model time of acceptance.
    task automatic send_word(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l,
                             output int acc_t);
        logic acc;
        acc_t = -1;
        up_v  = 1'b1;
        up_h  = h;
        up_p  = p;
        up_l  = l;
        for (int i = 0; i < 3 * FRAME; i++) begin
            acc_t = t;
            tick(1'b1, acc);
            if (acc) break;
            acc_t = -1;
        end
        if (acc_t < 0) check_eq("send_timeout", 32'd0, 32'd1);
        up_v = 1'b0;
    endtask

    initial begin
        logic acc;
        int   t1;
        int   t2;
        up_v = 1'b0;
        up_h = 16'h0000;
        up_p = 4'h0;
        up_l = 4'h0;
        u_if.upd_valid = 1'b0;
        u_if.upd_hexs  = 16'h0000;
        u_if.upd_point = 4'h0;
        u_if.upd_les   = 4'h0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        tick(1'b0, acc);
        tick(1'b0, acc);

        // Frame-aligned update raised at cycle 5 of the first frame.
        for (int i = 0; i < 5; i++) tick(1'b1, acc);
        send_word(16'h1234, 4'hE, 4'h0, t1);
        check_eq("acc_1234_t", t1, 15);

        // Back-to-back updates: second word taken exactly one frame after the first.
        send_word(16'hABCD, 4'h3, 4'h0, t1);
        send_word(16'h5555, 4'h7, 4'h0, t2);
        check_eq("b2b_gap", t2 - t1, FRAME);

        // Blink enables, then ten idle frames.
        send_word(16'h9876, 4'h0, 4'h5, t1);
        for (int i = 0; i < 10 * FRAME; i++) tick(1'b1, acc);

        // Reset mid-frame at Scan=2 with valid asserted.
        for (int i = 0; i < FRAME && (t % FRAME) != 2 * SD; i++) tick(1'b1, acc);
        up_v = 1'b1;
        up_h = 16'h7777;
        tick(1'b0, acc);
        up_v = 1'b0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic r;
            if (!up_v && ($urandom % 4) == 0) begin
                up_v = 1'b1;
                up_h = 16'($urandom);
                up_p = 4'($urandom);
                up_l = 4'($urandom);
            end
            r = (($urandom % 150) != 0);
            tick(r, acc);
            if (acc) up_v = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Sequencer for the 4-digit 7-segment scan multiplexer.
- Generates the 2-bit Scan digit select from a programmable clock divider.
- Holds the active Hexs/Point/Les words that feed the multiplexer, loading them from an upstream valid/ready update port only at frame boundaries so no frame shows mixed old/new digits.
- Produces a frame-rate blink phase that gates the per-digit Les outputs.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (>=2)
BLINK_FRAMES, 64, complete frames per blink half-period (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  synchronous active-low reset
upd_valid  input  1  upstream holds new display word
upd_ready  output  1  combinational; high only in the accept cycle
upd_hexs  input  16  new hex digits, [3:0]=digit 0
upd_point  input  4  new decimal-point bits, bit i = digit i
upd_les  input  4  new blink-enable bits, bit i = digit i
Hexs  output  16  active hex word to mux, registered
Point  output  4  active point bits to mux, registered
Les  output  4  active_les & {4{blink_phase}}, combinational from registers
Scan  output  2  current digit select, registered
frame_start  output  1  one-cycle pulse in first cycle of Scan=0 of each frame
blink_phase  output  1  blink phase, registered

Behaviour:
- Reset: applied on any clk edge with rstn=0, including mid-frame or mid-handshake.
  - div=0, Scan=0, Hexs=16'h0000, Point=4'hF, active_les=4'h0.
  - frame_cnt=0, blink_phase=0, frame_start=0.
  - upd_ready=0 while rstn=0. No transfer occurs in a reset cycle.
- Divider: div counts 0..SCAN_DIV-1. tick = (div==SCAN_DIV-1). On tick, div goes to 0 and Scan increments mod 4 (3->0 wraps).
- Digit timing: each Scan value is held exactly SCAN_DIV cycles. One frame is 4*SCAN_DIV cycles.
- Frame end: frame_end = tick && Scan==3.
- frame_start: registered from frame_end, so it is high in the cycle Scan first reads 0 (after reset release the first pulse comes only at the first wrap).
- Update handshake: upd_ready = frame_end && rstn. A transfer occurs when upd_valid && upd_ready.
- On a transfer, Hexs/Point/active_les load the upd_* values at the same edge Scan becomes 0. New content therefore appears from digit 0 of the next frame.
- upd_valid outside a frame_end cycle is ignored. The upstream must hold valid and data stable until it sees ready.
- Maximum acceptance rate is one update per frame. An update held for several frames is taken once, at the first frame_end.
- Without a transfer, the active registers keep their values indefinitely.
- Blink: frame_cnt advances on each frame_end, counting 0..BLINK_FRAMES-1.
  - At frame_end with frame_cnt==BLINK_FRAMES-1, frame_cnt goes to 0 and blink_phase toggles.
  - The toggle shares the edge with Scan wrap and any update, so the phase changes only at frame boundaries.
- Les: Les = active_les & {4{blink_phase}}. The downstream mux selects the bit for the current Scan.
- Simultaneous events: transfer, blink toggle, Scan wrap and frame_start generation can all coincide. Each applies independently; none has priority or delays another.
- Width rules: div is clog2(SCAN_DIV) bits and frame_cnt is clog2(BLINK_FRAMES) bits (minimum 1). Neither ever exceeds its terminal value.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2, so frame = 16 cycles):
- Reset/scan: hold rstn=0 for 3 cycles, then release.
  - During reset: Scan=0, Hexs=0, Point=F, Les=0.
  - After release: Scan steps 0,1,2,3 every 4 cycles and wraps to 0 at cycle 16.
  - frame_start first pulses at cycle 16, then every 16 cycles.
- Frame-aligned update: raise upd_valid with upd_hexs=16'h1234, upd_point=4'hE, upd_les=4'h0 at cycle 5.
  - upd_ready is high only at cycle 15.
  - Hexs=1234 and Point=E from cycle 16, with Scan=0. No change before cycle 16.
- Back-to-back updates: hold valid with 16'hABCD for 40 cycles.
  - Exactly one acceptance at the first frame_end.
  - Change data to 16'h5555 after ready; it is accepted at the next frame_end, 16 cycles later.
- Blink: load upd_les=4'h5.
  - Les=0 for frames with blink_phase=0, Les=5 for frames with blink_phase=1.
  - blink_phase toggles every 32 cycles, coincident with frame_start.
- Reset mid-operation: deassert rstn at Scan=2 while upd_valid=1.
  - Next edge: all outputs return to reset values and upd_ready=0.
  - After release: counting restarts from div=0, Scan=0.
- Idle hold: no upd_valid for 10 frames.
  - Hexs/Point unchanged.
  - Scan and blink timing continue without drift: Scan period 16, blink period 64.
